red_seq: RTL and testbench

RED_SEQ -- requirements
Module: red_seq

---
 rtl/red_seq.sv | 111 +++++++++++
 tb/tb_red_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/red_seq.sv
// red_seq: sequential signed byte-pair reduction built around one shared adder.
// Ports: clk, rst (sync, active-high), start, A[15:0], B[15:0] in; busy, done, Sum[15:0] out.
module red_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic        busy,
    output logic        done,
    output logic [15:0] Sum
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_FIN
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [8:0]  r_hold_hi;
    logic [8:0]  r_hold_lo;
    logic [15:0] r_sum;
    logic        r_done;
    logic [9:0]  w_opa;
    logic [9:0]  w_opb;
    logic [9:0]  w_add;

    // The one shared adder. Byte sums need 9 bits; the combine step
    // spans -512..+508, which needs a tenth bit, so the adder is one
    // bit wider than a byte sum and is reused in all three states.
    always_comb begin
        w_opa = '0;
        w_opb = '0;
        unique case (r_state)
            S_HI: begin
                w_opa = {{2{r_a[15]}}, r_a[15:8]};
                w_opb = {{2{r_b[15]}}, r_b[15:8]};
            end
            S_LO: begin
                w_opa = {{2{r_a[7]}}, r_a[7:0]};
                w_opb = {{2{r_b[7]}}, r_b[7:0]};
            end
            S_FIN: begin
                w_opa = {r_hold_hi[8], r_hold_hi};
                w_opb = {r_hold_lo[8], r_hold_lo};
            end
            default: begin
            end
        endcase
    end

    assign w_add = w_opa + w_opb;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  w_next = start ? S_HI : S_IDLE;
            S_HI:    w_next = S_LO;
            S_LO:    w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_hold_hi <= '0;
            r_hold_lo <= '0;
            r_sum     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Operands are captured only on acceptance, so starts
            // arriving mid-reduction cannot disturb the result.
            if (r_state == S_IDLE && start) begin
                r_a <= A;
                r_b <= B;
            end
            if (r_state == S_HI) begin
                r_hold_hi <= w_add[8:0];
            end
            if (r_state == S_LO) begin
                r_hold_lo <= w_add[8:0];
            end
            if (r_state == S_FIN) begin
                r_sum  <= {{6{w_add[9]}}, w_add};
                r_done <= 1'b1;
            end
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign Sum  = r_sum;

endmodule

// File: tb/tb_red_seq.sv
// Bench for red_seq: per-cycle reference model comparison plus
// directed vectors with hand-computed sums, latency and done counts.
module tb_red_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Sum;

    int n_cmp;
    int n_err;
    int cyc;

    // reference model state
    bit          m_valid;
    int          m_left;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [15:0] m_sum;
    logic        m_done;

    red_seq dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .A    (A),
        .B    (B),
        .busy (busy),
        .done (done),
        .Sum  (Sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] ref_sum(input logic [15:0] a, input logic [15:0] b);
        int ah;
        int al;
        int bh;
        int bl;
        ah = $signed(a[15:8]);
        al = $signed(a[7:0]);
        bh = $signed(b[15:8]);
        bl = $signed(b[7:0]);
        return 16'((ah + bh) + (al + bl));
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: a reduction, once accepted, occupies three more edges;
    // the result appears together with done after the third.
    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_valid = 1'b1;
            m_left  = 0;
            m_a     = '0;
            m_b     = '0;
            m_sum   = '0;
            m_done  = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_sum  = ref_sum(m_a, m_b);
                    m_done = 1'b1;
                end
            end else if (start) begin
                m_a    = A;
                m_b    = B;
                m_left = 3;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", {15'd0, busy}, {15'd0, (m_left > 0)});
            chk("done", {15'd0, done}, {15'd0, m_done});
            chk("Sum", Sum, m_sum);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Pulse start, wait for done (bounded), check latency and result.
    task automatic run(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] exp, input string name);
        int lat;
        bit got;
        A     = a;
        B     = b;
        start = 1'b1;
        step();
        start = 1'b0;
        A     = 16'hDEAD;
        B     = 16'hBEEF;
        lat   = 0;
        got   = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step();
            lat++;
            if (done) got = 1'b1;
        end
        chk({name, "_got_done"}, {15'd0, got}, 16'd1);
        chk({name, "_latency"}, 16'(lat), 16'd3);
        chk({name, "_sum"}, Sum, exp);
        step();
    endtask

    int dcount;
    int last;
    int gap_bad;

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        m_valid = 1'b0;
        m_left  = 0;
        rst     = 1'b1;
        start   = 1'b0;
        A       = '0;
        B       = '0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("reset_sum", Sum, 16'h0000);
        chk("reset_busy", {15'd0, busy}, 16'd0);
        chk("reset_done", {15'd0, done}, 16'd0);

        // literal pins for the model arithmetic
        chk("model_000A", ref_sum(16'h0102, 16'h0304), 16'h000A);
        chk("model_FF81", ref_sum(16'hFF01, 16'h0180), 16'hFF81);

        run(16'h0102, 16'h0304, 16'h000A, "basic");
        run(16'h7F7F, 16'h7F7F, 16'h01FC, "maxpos");
        run(16'h8080, 16'h8080, 16'hFE00, "maxneg");
        run(16'hFF01, 16'h0180, 16'hFF81, "mixed");

        // start while busy is ignored
        A     = 16'h0101;
        B     = 16'h0101;
        start = 1'b1;
        step();
        A = 16'h7F7F;
        step();
        step();
        start  = 1'b0;
        dcount = 0;
        for (int i = 0; i < 3; i++) begin
            if (done) dcount++;
            step();
        end
        chk("busy_ign_dones", 16'(dcount), 16'd1);
        chk("busy_ign_sum", Sum, 16'h0004);

        // reset during LO aborts without done
        A     = 16'h0102;
        B     = 16'h0304;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {15'd0, busy}, 16'd0);
        chk("abort_sum", Sum, 16'h0000);
        dcount = 0;
        for (int i = 0; i < 5; i++) begin
            if (done) dcount++;
            step();
        end
        chk("abort_no_done", 16'(dcount), 16'd0);
        run(16'h0304, 16'h0102, 16'h000A, "after_abort");

        // start coincident with reset is dropped
        rst   = 1'b1;
        start = 1'b1;
        step();
        rst   = 1'b0;
        start = 1'b0;
        chk("rst_start_busy", {15'd0, busy}, 16'd0);
        step();

        // start held high: back-to-back every 4 cycles
        A       = 16'h0102;
        B       = 16'h0304;
        start   = 1'b1;
        dcount  = 0;
        last    = -1;
        gap_bad = 0;
        for (int i = 0; i < 17; i++) begin
            step();
            if (done) begin
                if (last >= 0 && (i - last) != 4) gap_bad++;
                if (Sum !== 16'h000A) gap_bad++;
                last = i;
                dcount++;
            end
        end
        start = 1'b0;
        chk("b2b_dones", 16'(dcount), 16'd4);
        chk("b2b_gaps", 16'(gap_bad), 16'd0);
        step();
        step();
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
